// File: rtl/srff_bank.sv
// srff_bank: WIDTH-channel bank of clocked set/reset flip-flops with a
// selectable S=R=1 resolution mode, registered rise/fall edge pulses, and
// conflict reporting (per-channel sticky bits plus a saturating counter of
// conflict cycles).
//
// Optional build macro: SRFF_BANK_FILTER_EN
//   When defined, every s and r bit passes through a qualify filter: the
//   filtered bit is high only on the FILT_CYCLES-th and later consecutive
//   high samples of the raw bit, and drops on the first low sample.
//   When undefined, raw s/r feed the S/R logic and no filter flops exist.
//
// No handshakes and no FSM: every output is a plain register updated on
// the rising clock edge, or cleared asynchronously by rst_n.
module srff_bank #(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0,
  parameter int               CNT_W         = 8,
  parameter int               FILT_CYCLES   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Out-of-range modes fall back to hold.
  localparam int MODE = ((CONFLICT_MODE >= 0) && (CONFLICT_MODE <= 3)) ? CONFLICT_MODE : 0;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] r_eff;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict;
  logic             any_conflict;

`ifdef SRFF_BANK_FILTER_EN
  // Each counter holds the number of consecutive high samples seen before
  // the current edge. The bit qualifies at the edge that delivers the
  // FILT_CYCLES-th high sample, so the filter adds FILT_CYCLES-1 edges on
  // top of the normal one-edge register latency.
  localparam int               FC_W    = $clog2(FILT_CYCLES + 1);
  localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(FILT_CYCLES);
  localparam logic [FC_W-1:0]  FC_QUAL = FC_W'(FILT_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);

  logic [FC_W-1:0] s_cnt [WIDTH];
  logic [FC_W-1:0] r_cnt [WIDTH];

  // Run-length counters for the raw inputs; free-running, independent of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        s_cnt[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!s[i])                s_cnt[i] <= '0;
        else if (s_cnt[i] != FC_MAX) s_cnt[i] <= s_cnt[i] + FC_ONE;
        if (!r[i])                r_cnt[i] <= '0;
        else if (r_cnt[i] != FC_MAX) r_cnt[i] <= r_cnt[i] + FC_ONE;
      end
    end
  end

  // Qualified request: raw bit high now and long enough before.
  always_comb begin
    s_eff = '0;
    r_eff = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s_eff[i] = s[i] && (s_cnt[i] >= FC_QUAL);
      r_eff[i] = r[i] && (r_cnt[i] >= FC_QUAL);
    end
  end
`else
  assign s_eff = s;
  assign r_eff = r;
`endif

  assign conflict     = s_eff & r_eff;
  assign any_conflict = |conflict;

  // Per-channel S/R resolution, including the S=R=1 mode.
  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s_eff[i], r_eff[i]})
        2'b10:   q_next[i] = 1'b1;
        2'b01:   q_next[i] = 1'b0;
        2'b11: begin
          case (MODE)
            1:       q_next[i] = 1'b1;
            2:       q_next[i] = 1'b0;
            3:       q_next[i] = ~q[i];
            default: q_next[i] = q[i];
          endcase
        end
        default: q_next[i] = q[i];
      endcase
    end
  end

  // State and edge pulses; pulses are derived from the transition being
  // committed so they line up with the cycle q shows the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RESET_VAL;
      rise <= '0;
      fall <= '0;
    end else if (en) begin
      q    <= q_next;
      rise <= q_next & ~q;
      fall <= ~q_next & q;
    end else begin
      rise <= '0;
      fall <= '0;
    end
  end

  // Conflict reporting; a conflict in the clearing cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_sticky <= '0;
      conflict_cnt    <= '0;
    end else if (clr_conflict) begin
      conflict_sticky <= en ? conflict : '0;
      conflict_cnt    <= (en && any_conflict) ? CNT_ONE : '0;
    end else if (en) begin
      conflict_sticky <= conflict_sticky | conflict;
      if (any_conflict && (conflict_cnt != CNT_MAX))
        conflict_cnt <= conflict_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_srff_bank.sv
// tb_srff_bank: four srff_bank instances (one per CONFLICT_MODE) share the
// same stimulus. A behavioural model computes expected outputs from the
// channel rules; a negedge compare process checks every output each cycle.
// Directed sections pin the model with literal expectations.
module tb_srff_bank;

  localparam int W     = 8;
  localparam int CW    = 4;
  localparam int FILT  = 3;
  localparam int CMAX  = 15;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [W-1:0]  s;
  logic [W-1:0]  r;
  logic          clr_conflict;
  logic [W-1:0]  q_a    [4];
  logic [W-1:0]  rise_a [4];
  logic [W-1:0]  fall_a [4];
  logic [W-1:0]  st_a   [4];
  logic [CW-1:0] cnt_a  [4];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    srff_bank #(
      .WIDTH(W), .CONFLICT_MODE(g), .RESET_VAL(8'h00), .CNT_W(CW), .FILT_CYCLES(FILT)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_conflict(clr_conflict),
      .q(q_a[g]), .rise(rise_a[g]), .fall(fall_a[g]),
      .conflict_sticky(st_a[g]), .conflict_cnt(cnt_a[g])
    );
  end

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] mq    [4];
  logic [W-1:0] mrise [4];
  logic [W-1:0] mfall [4];
  logic [W-1:0] mst;
  int           mcnt;
  int           s_run [W];
  int           r_run [W];
  logic [W-1:0] exp_q [$];   // expected q per mode, pushed at posedge, popped at negedge

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      mq[m] = 8'h00; mrise[m] = 8'h00; mfall[m] = 8'h00;
    end
    mst  = 8'h00;
    mcnt = 0;
    for (int i = 0; i < W; i++) begin
      s_run[i] = 0; r_run[i] = 0;
    end
    exp_q.delete();
  endtask

  function automatic logic next_bit(int m, logic qb, logic sb, logic rb);
    if (sb && !rb) return 1'b1;
    if (rb && !sb) return 1'b0;
    if (!sb && !rb) return qb;
    case (m)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return !qb;
      default: return qb;
    endcase
  endfunction

  always @(posedge clk) begin
    if (chk_on && rst_n) begin
      logic [W-1:0] se, re, cf, nq;
`ifdef SRFF_BANK_FILTER_EN
      for (int i = 0; i < W; i++) begin
        s_run[i] = s[i] ? s_run[i] + 1 : 0;
        r_run[i] = r[i] ? r_run[i] + 1 : 0;
        se[i] = (s_run[i] >= FILT);
        re[i] = (r_run[i] >= FILT);
      end
`else
      se = s;
      re = r;
`endif
      for (int m = 0; m < 4; m++) begin
        for (int i = 0; i < W; i++) nq[i] = next_bit(m, mq[m][i], se[i], re[i]);
        if (en) begin
          mrise[m] = nq & ~mq[m];
          mfall[m] = ~nq & mq[m];
          mq[m]    = nq;
        end else begin
          mrise[m] = 8'h00;
          mfall[m] = 8'h00;
        end
        exp_q.push_back(mq[m]);
      end
      cf = se & re;
      if (clr_conflict) begin
        mst  = en ? cf : 8'h00;
        mcnt = (en && cf != 0) ? 1 : 0;
      end else if (en && cf != 0) begin
        mst  = mst | cf;
        mcnt = (mcnt < CMAX) ? mcnt + 1 : CMAX;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      logic [W-1:0] eq [4];
      for (int m = 0; m < 4; m++) eq[m] = mq[m];
      if (exp_q.size() >= 4) begin
        for (int m = 0; m < 4; m++) eq[m] = exp_q.pop_front();
      end
      for (int m = 0; m < 4; m++) begin
        check($sformatf("cyc_q_m%0d", m),    q_a[m],    eq[m]);
        check($sformatf("cyc_rise_m%0d", m), rise_a[m], mrise[m]);
        check($sformatf("cyc_fall_m%0d", m), fall_a[m], fall_a[m] === mfall[m] ? mfall[m] : mfall[m]);
        check($sformatf("cyc_st_m%0d", m),   st_a[m],   mst);
        check($sformatf("cyc_cnt_m%0d", m),  cnt_a[m],  mcnt[CW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; s = '0; r = '0; clr_conflict = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_all_q(input string name, input logic [W-1:0] v);
    for (int m = 0; m < 4; m++) check($sformatf("%s_m%0d", name, m), q_a[m], v);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    chk_on = 1'b1;
    step();
    step();
    // every output is 0 while reset is held
    for (int m = 0; m < 4; m++) begin
      check("rst_q", q_a[m], 8'h00);
      check("rst_rise", rise_a[m], 8'h00);
      check("rst_fall", fall_a[m], 8'h00);
      check("rst_sticky", st_a[m], 8'h00);
      check("rst_cnt", cnt_a[m], 4'd0);
    end
    rst_n = 1'b1;
    step();

`ifndef SRFF_BANK_FILTER_EN
    // basic set then reset
    s = 8'h0F; step();
    check_all_q("t1_q_set", 8'h0F);
    check("t1_rise", rise_a[0], 8'h0F);
    s = 8'h00; r = 8'h03; step();
    check_all_q("t1_q_clr", 8'h0C);
    check("t1_fall", fall_a[0], 8'h03);
    check("t1_rise0", rise_a[0], 8'h00);

    // S=R=1 resolution per mode
    idle_inputs(); do_reset();
    s = 8'h01; r = 8'h01;
    step();
    check("t2_m3_q1", q_a[3], 8'h01); check("t2_m3_rise1", rise_a[3], 8'h01);
    step();
    check("t2_m3_q2", q_a[3], 8'h00); check("t2_m3_fall2", fall_a[3], 8'h01);
    step();
    check("t2_m3_q3", q_a[3], 8'h01); check("t2_m3_rise3", rise_a[3], 8'h01);
    check("t2_m0_q", q_a[0], 8'h00);
    check("t2_m1_q", q_a[1], 8'h01);
    check("t2_m2_q", q_a[2], 8'h00);
    for (int m = 0; m < 4; m++) begin
      check("t2_sticky", st_a[m], 8'h01);
      check("t2_cnt", cnt_a[m], 4'd3);
    end

    // saturation
    idle_inputs(); do_reset();
    s = 8'hFF; r = 8'hFF;
    for (int k = 0; k < 20; k++) step();
    check("t3_cnt_sat", cnt_a[0], 4'd15);
    check("t3_sticky", st_a[0], 8'hFF);

    // clear colliding with a new conflict
    idle_inputs(); do_reset();
    s = 8'hFF; r = 8'hFF;
    for (int k = 0; k < 5; k++) step();
    check("t4_cnt5", cnt_a[0], 4'd5);
    s = 8'h10; r = 8'h10; clr_conflict = 1'b1; step();
    check("t4_sticky_win", st_a[0], 8'h10);
    check("t4_cnt_win", cnt_a[0], 4'd1);
    s = 8'h00; r = 8'h00; step();
    check("t4_sticky_clr", st_a[0], 8'h00);
    check("t4_cnt_clr", cnt_a[0], 4'd0);
    clr_conflict = 1'b0;

    // enable freeze, then async reset mid-cycle
    en = 1'b0; s = 8'hFF; r = 8'h00; step(); step();
    check("t5_frz_q", q_a[0], 8'h00);
    check("t5_frz_rise", rise_a[0], 8'h00);
    check("t5_frz_cnt", cnt_a[0], 4'd0);
    en = 1'b1; s = 8'hAA; r = 8'h55; step();
    check_all_q("t5_q_aa", 8'hAA);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_q("t5_async_rst", 8'h00);
    step();
    rst_n = 1'b1;
    idle_inputs();
    step();
`else
    // qualify filter: short pulse ignored, long pulse lands after FILT edges
    s = 8'h01; step(); step();
    s = 8'h00; step(); step();
    check("t6_short_q", q_a[0], 8'h00);
    s = 8'h01; step();
    check("t6_edge1", q_a[0], 8'h00);
    step();
    check("t6_edge2", q_a[0], 8'h00);
    step();
    check("t6_edge3", q_a[0], 8'h01);
    idle_inputs(); do_reset();
`endif

    // randomized phase; inputs hold a few cycles so the filter can qualify
    for (int k = 0; k < 3000; ) begin
      int hold;
      en           = ($urandom_range(0, 9) != 0);
      s            = W'($urandom & $urandom);
      r            = W'($urandom & $urandom);
      clr_conflict = ($urandom_range(0, 15) == 0);
      hold         = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        step();
        k++;
      end
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end
    end

    idle_inputs();
    step();
    step();
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
